// File: rtl/alarm_pkg.sv
// ============================================================================
// alarm_pkg : shared types, field limits and helpers for alarm_time_set
// Revision  : 1.0
// ============================================================================
`default_nettype none

package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET_HH = 2'd1,
        ST_SET_MM = 2'd2,
        ST_SET_SS = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HH   = 2'd1,
        FLD_MM   = 2'd2,
        FLD_SS   = 2'd3
    } field_t;

    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    function automatic field_t sel_field(input state_t st);
        case (st)
            ST_SET_HH: return FLD_HH;
            ST_SET_MM: return FLD_MM;
            ST_SET_SS: return FLD_SS;
            default:   return FLD_NONE;
        endcase
    endfunction

    // Wrapping +/-1 on a field whose legal range is 0..vmax.
    function automatic logic [5:0] step_field(input logic [5:0] v,
                                              input logic [5:0] vmax,
                                              input logic       up);
        if (up)
            return (v >= vmax) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    // Returns {tens, ones} BCD for a 0..63 binary value.
    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        if (v >= 6'd60) begin
            tens = 4'd6; rem = v - 6'd60;
        end else if (v >= 6'd50) begin
            tens = 4'd5; rem = v - 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4; rem = v - 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3; rem = v - 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2; rem = v - 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1; rem = v - 6'd10;
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_time_set_btn_debounce.sv
// ============================================================================
// btn_debounce : 2-FF synchronizer, level debouncer and rising-edge press pulse
// Revision     : 1.0
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          sample;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer flops carry no reset; they flush within two cycles.
    always_ff @(posedge clk) begin
        sync_q <= {sync_q[0], btn_i};
    end

    assign sample = sync_q[1];

    // Until a stable low is seen after reset the debouncer stays disarmed,
    // so a button held across reset release cannot generate a press.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!armed_q) begin
            if (sample) begin
                cnt_d = '0;
            end else if (cnt_q == C_LAST) begin
                cnt_d   = '0;
                armed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            cnt_d   = '0;
            level_d = sample;
            press_d = sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/alarm_time_set.sv
// ============================================================================
// alarm_time_set : three-button HH:MM:SS alarm editor with blinking field
// Revision       : 1.0
// ============================================================================
`default_nettype none

module alarm_time_set
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_mode,
    input  logic            btn_up,
    input  logic            btn_down,
    output logic [5:0][3:0] digits,
    output logic [5:0]      digit_en,
    output logic            set_done,
    output logic [4:0]      alarm_hh,
    output logic [5:0]      alarm_mm,
    output logic [5:0]      alarm_ss
);

    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic mode_p, up_p, down_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst(rst), .btn_i(btn_mode), .press_o(mode_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .btn_i(btn_up), .press_o(up_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .btn_i(btn_down), .press_o(down_p)
    );

    state_t        state_q, state_d;
    logic [4:0]    work_hh_q, work_hh_d, com_hh_q, com_hh_d;
    logic [5:0]    work_mm_q, work_mm_d, com_mm_q, com_mm_d;
    logic [5:0]    work_ss_q, work_ss_d, com_ss_q, com_ss_d;
    logic          set_done_q, set_done_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          hidden_q, hidden_d;

    logic          step_en, step_up, field_upd;

    // Mode wins over up/down; opposing up+down cancel; nothing edits in IDLE.
    assign step_en   = (state_q != ST_IDLE) && !mode_p && (up_p ^ down_p);
    assign step_up   = up_p;
    assign field_upd = step_en;

    always_comb begin
        state_d    = state_q;
        work_hh_d  = work_hh_q;
        work_mm_d  = work_mm_q;
        work_ss_d  = work_ss_q;
        com_hh_d   = com_hh_q;
        com_mm_d   = com_mm_q;
        com_ss_d   = com_ss_q;
        set_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode_p) begin
                    state_d   = ST_SET_HH;
                    work_hh_d = com_hh_q;
                    work_mm_d = com_mm_q;
                    work_ss_d = com_ss_q;
                end
            end
            ST_SET_HH: begin
                if (mode_p)
                    state_d = ST_SET_MM;
                else if (step_en)
                    work_hh_d = 5'(step_field({1'b0, work_hh_q}, {1'b0, HH_MAX}, step_up));
            end
            ST_SET_MM: begin
                if (mode_p)
                    state_d = ST_SET_SS;
                else if (step_en)
                    work_mm_d = step_field(work_mm_q, MS_MAX, step_up);
            end
            ST_SET_SS: begin
                if (mode_p) begin
                    state_d    = ST_IDLE;
                    com_hh_d   = work_hh_q;
                    com_mm_d   = work_mm_q;
                    com_ss_d   = work_ss_q;
                    set_done_d = 1'b1;
                end else if (step_en) begin
                    work_ss_d = step_field(work_ss_q, MS_MAX, step_up);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any state change or field edit restarts the blink in the visible phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;
        if ((state_q == ST_IDLE) || (state_d != state_q) || field_upd) begin
            blink_cnt_d = '0;
            hidden_d    = 1'b0;
        end else if (blink_cnt_q == C_BLINK_LAST) begin
            blink_cnt_d = '0;
            hidden_d    = ~hidden_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            work_hh_q   <= '0;
            work_mm_q   <= '0;
            work_ss_q   <= '0;
            com_hh_q    <= '0;
            com_mm_q    <= '0;
            com_ss_q    <= '0;
            set_done_q  <= 1'b0;
            blink_cnt_q <= '0;
            hidden_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_hh_q   <= work_hh_d;
            work_mm_q   <= work_mm_d;
            work_ss_q   <= work_ss_d;
            com_hh_q    <= com_hh_d;
            com_mm_q    <= com_mm_d;
            com_ss_q    <= com_ss_d;
            set_done_q  <= set_done_d;
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
        end
    end

    logic       show_work;
    logic [4:0] show_hh;
    logic [5:0] show_mm, show_ss;

    assign show_work = (state_q != ST_IDLE);
    assign show_hh   = show_work ? work_hh_q : com_hh_q;
    assign show_mm   = show_work ? work_mm_q : com_mm_q;
    assign show_ss   = show_work ? work_ss_q : com_ss_q;

    assign digits = {bin2bcd({1'b0, show_hh}), bin2bcd(show_mm), bin2bcd(show_ss)};

    always_comb begin
        digit_en = 6'b111111;
        if (hidden_q) begin
            case (sel_field(state_q))
                FLD_HH:  digit_en[5:4] = 2'b00;
                FLD_MM:  digit_en[3:2] = 2'b00;
                FLD_SS:  digit_en[1:0] = 2'b00;
                default: digit_en      = 6'b111111;
            endcase
        end
    end

    assign set_done = set_done_q;
    assign alarm_hh = com_hh_q;
    assign alarm_mm = com_mm_q;
    assign alarm_ss = com_ss_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_time_set.sv
// ============================================================================
// tb_alarm_time_set : directed + randomized checks against a behavioural model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_time_set;

    localparam int DB = 4;
    localparam int BL = 8;

    logic            clk = 1'b0;
    logic            rst, btn_mode, btn_up, btn_down;
    logic [5:0][3:0] digits;
    logic [5:0]      digit_en;
    logic            set_done;
    logic [4:0]      alarm_hh;
    logic [5:0]      alarm_mm, alarm_ss;

    alarm_time_set #(.DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .digits(digits), .digit_en(digit_en), .set_done(set_done),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=idle, 1=hours, 2=minutes, 3=seconds
    int m_st;
    int w_h, w_m, w_s;
    int a_h, a_m, a_s;
    int exp_done = 0;

    int done_cnt = 0, done_run = 0, done_wide = 0;

    always @(negedge clk) begin
        if (set_done === 1'b1) begin
            done_cnt++;
            done_run++;
            if (done_run > 1) done_wide = 1;
        end else begin
            done_run = 0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        w_h = 0; w_m = 0; w_s = 0;
        a_h = 0; a_m = 0; a_s = 0;
    endtask

    task automatic model_apply(input bit m, input bit u, input bit d);
        if (m) begin
            if (m_st == 0) begin
                m_st = 1; w_h = a_h; w_m = a_m; w_s = a_s;
            end else if (m_st == 3) begin
                m_st = 0; a_h = w_h; a_m = w_m; a_s = w_s; exp_done++;
            end else begin
                m_st++;
            end
        end else if (u != d && m_st != 0) begin
            case (m_st)
                1: w_h = u ? (w_h + 1) % 24 : (w_h + 23) % 24;
                2: w_m = u ? (w_m + 1) % 60 : (w_m + 59) % 60;
                default: w_s = u ? (w_s + 1) % 60 : (w_s + 59) % 60;
            endcase
        end
    endtask

    function automatic logic [23:0] exp_digits();
        int h, m, s;
        h = (m_st == 0) ? a_h : w_h;
        m = (m_st == 0) ? a_m : w_m;
        s = (m_st == 0) ? a_s : w_s;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic press(input bit m, input bit u, input bit d);
        @(posedge clk); #1;
        btn_mode = m; btn_up = u; btn_down = d;
        repeat (8) @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (10) @(posedge clk);
        model_apply(m, u, d);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_digits"}, 32'(digits), 32'(exp_digits()));
        chk({tag, "_alarm_hh"}, 32'(alarm_hh), 32'(a_h));
        chk({tag, "_alarm_mm"}, 32'(alarm_mm), 32'(a_m));
        chk({tag, "_alarm_ss"}, 32'(alarm_ss), 32'(a_s));
        chk({tag, "_set_done_count"}, 32'(done_cnt), 32'(exp_done));
        if (m_st == 0) chk({tag, "_digit_en_idle"}, 32'(digit_en), 32'h3F);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int n, len, bad;
        logic [23:0] old_dig;

        rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset_set_done", 32'(set_done), 32'd0);

        // Bouncing up button in SET_HH must count once
        press(1, 0, 0);
        @(posedge clk); #1;
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (2) @(posedge clk);
            #1 btn_up = ~btn_up;
        end
        btn_up = 1'b1;
        repeat (10) @(posedge clk);
        #1 btn_up = 1'b0;
        repeat (10) @(posedge clk);
        model_apply(0, 1, 0);
        @(negedge clk);
        chk("bounce_hh_bcd", 32'(digits[5:4]), 32'h01);
        check_all("bounce");

        // Wrap boundaries
        repeat (22) press(0, 1, 0);
        chk("hh_at_23", 32'(digits[5:4]), 32'h23);
        press(0, 1, 0);
        chk("hh_wrap_up", 32'(digits[5:4]), 32'h00);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("mm_wrap_down", 32'(digits[3:2]), 32'h59);
        check_all("wrap");

        // Reset mid-edit discards working values
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_all("midreset");
        chk("midreset_digit_en", 32'(digit_en), 32'h3F);
        chk("midreset_no_done", 32'(done_cnt), 32'd0);

        // Full edit to 12:34:56
        press(1, 0, 0);
        repeat (12) press(0, 1, 0);
        press(1, 0, 0);
        repeat (34) press(0, 1, 0);
        press(1, 0, 0);
        repeat (56) press(0, 1, 0);
        press(1, 0, 0);
        chk("full_done_count", 32'(done_cnt), 32'd1);
        chk("full_alarm", {alarm_hh, alarm_mm, alarm_ss}, {5'd12, 6'd34, 6'd56});
        chk("full_digits", 32'(digits), 32'h123456);
        chk("full_digit_en", 32'(digit_en), 32'h3F);
        check_all("full");

        // Blink in SET_MM
        press(1, 0, 0);
        press(1, 0, 0);
        n = 0;
        while (digit_en !== 6'b111111 && n < 40) begin @(negedge clk); n++; end
        while (digit_en === 6'b111111 && n < 80) begin @(negedge clk); n++; end
        chk("blink_found", 32'(n < 80), 32'd1);
        chk("blink_hidden_value", 32'(digit_en), 32'h33);
        len = 0;
        while (digit_en === 6'b110011 && len < 20) begin @(negedge clk); len++; end
        chk("blink_hidden_len", 32'(len), 32'(BL));
        len = 0;
        while (digit_en === 6'b111111 && len < 20) begin @(negedge clk); len++; end
        chk("blink_visible_len", 32'(len), 32'(BL));

        // Up press during hidden phase restarts visible phase
        old_dig = digits;
        btn_up = 1'b1;
        n = 0;
        while (digits === old_dig && n < 30) begin @(negedge clk); n++; end
        chk("blink_up_seen", 32'(n < 30), 32'd1);
        chk("blink_up_visible", 32'(digit_en), 32'h3F);
        len = 0;
        while (digit_en === 6'b111111 && len < 20) begin
            @(negedge clk); len++;
            if (len == 3) btn_up = 1'b0;
        end
        btn_up = 1'b0;
        chk("blink_restart_len", 32'(len), 32'(BL));
        repeat (12) @(posedge clk);
        model_apply(0, 1, 0);
        @(negedge clk);
        check_all("blink_up");

        // Simultaneous up+down ignored; mode+up applies only mode
        press(1, 0, 0);
        press(0, 1, 1);
        check_all("updown_ss");
        press(1, 1, 0);
        check_all("mode_up_commit");
        press(0, 1, 0);
        check_all("idle_up");

        // Mode held through reset release must not register
        @(posedge clk); #1 btn_mode = 1'b1;
        repeat (12) @(posedge clk);
        model_apply(1, 0, 0);
        do_reset();
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (digit_en !== 6'b111111) bad = 1;
        end
        chk("held_reset_no_blink", 32'(bad), 32'd0);
        #1 btn_mode = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        press(0, 1, 0);
        check_all("held_reset");

        // Randomized operation sequence
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: press(1, 0, 0);
                3, 4, 5: press(0, 1, 0);
                6, 7:    press(0, 0, 1);
                8:       press(0, 1, 1);
                default: press(1, $urandom_range(0, 1) == 1, 1'b0);
            endcase
            check_all("rand");
        end
        while (m_st != 0) press(1, 0, 0);
        check_all("rand_final");
        chk("set_done_width", 32'(done_wide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alarm_time_set.md
ALARM_TIME_SET -- requirements
Module: alarm_time_set

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-cycle count before a button level is accepted.
REQ-002 Parameter BLINK_CYCLES, default 12500000, cycles per blink half-period.
REQ-003 clk  input  1  sole clock; all state rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_mode  input  1  raw, asynchronous, active-high; advances the edit field.
REQ-006 btn_up  input  1  raw, asynchronous, active-high; increments the selected field.
REQ-007 btn_down  input  1  raw, asynchronous, active-high; decrements the selected field.
REQ-008 digits  output  4 x [0:5]  BCD digits for the display; [5:4]=HH, [3:2]=MM, [1:0]=SS, tens digit first.
REQ-009 digit_en  output  6  per-digit display enable; bit i gates digits[i].
REQ-010 set_done  output  1  one-cycle pulse when a new alarm time is committed.
REQ-011 alarm_hh, alarm_mm, alarm_ss  output  5/6/6  committed alarm time, binary.

Function
REQ-012 Each button SHALL pass a 2-FF synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-013 A press event SHALL be a one-cycle pulse on the debounced 0->1 transition; holding a button SHALL NOT auto-repeat.
REQ-014 FSM states: IDLE, SET_HH, SET_MM, SET_SS.
REQ-015 Mode press: IDLE->SET_HH (working regs loaded from committed regs), SET_HH->SET_MM, SET_MM->SET_SS, SET_SS->IDLE.
REQ-016 On SET_SS->IDLE, working regs SHALL copy to committed regs and set_done SHALL pulse high for exactly that transition cycle +1 (registered, one cycle).
REQ-017 In SET_x, up press increments the field; down press decrements; HH wraps 23<->0, MM and SS wrap 59<->0.
REQ-018 Up and down press events in the same cycle SHALL be ignored.
REQ-019 Mode press coincident with up/down SHALL apply only the mode transition.
REQ-020 In IDLE, up/down presses SHALL be ignored.
REQ-021 Field updates SHALL be visible on digits one cycle after the press pulse.
REQ-022 digits SHALL show working regs in SET_x, committed regs in IDLE, converted binary->BCD combinationally from registers.
REQ-023 Blink counter SHALL run in SET_x, toggling phase every BLINK_CYCLES; counter and phase SHALL clear (phase=visible) on every state change and every field update.
REQ-024 digit_en: 6'b111111 in IDLE; in SET_x the two digits of the selected field SHALL be 0 during the hidden phase, all others 1.

Reset
REQ-025 rst SHALL force: state IDLE, committed and working regs 00:00:00, set_done 0, digit_en 6'b111111, blink counter/phase cleared, debouncer levels 0 and counters 0.
REQ-026 Reset mid-edit SHALL discard working values without committing and without pulsing set_done.
REQ-027 A button held through reset release SHALL NOT produce a press event until released and re-pressed.

Structure
REQ-028 Package alarm_pkg SHALL hold the FSM state enum, max field constants (23, 59), and the field-select type.
REQ-029 Debounce + edge detect SHALL be one sub-module, btn_debounce, instantiated three times.
REQ-030 Binary->BCD split SHALL be a function in alarm_pkg, not a sub-module.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
REQ-031 Bounce: btn_up toggles every 2 cycles for 20 cycles then holds 1, in SET_HH -> exactly one increment, HH 00->01.
REQ-032 Wrap: SET_HH at 23, one up -> 00; SET_MM at 00, one down -> 59; digits = 0,0 / 5,9.
REQ-033 Full edit: mode, up x12, mode, up x34, mode, up x56, mode -> set_done one pulse, alarm = 12:34:56, digits {1,2,3,4,5,6}, digit_en 6'b111111.
REQ-034 Blink: in SET_MM idle 8 cycles -> digit_en = 6'b110011 for 8 cycles, then 6'b111111; an up press restarts visible phase.
REQ-035 Simultaneous up+down press in SET_SS -> SS unchanged; up press in IDLE -> alarm unchanged.
REQ-036 Reset in SET_MM after edits -> IDLE, alarm remains previous committed value, set_done never asserted.
